freelist: RTL
=============

Name: freelist

Overview:
- Physical-register free list for the rename stage.
- Hands out up to 4 free physical registers per cycle to rename.
- Takes back up to 4 retired old physical registers per cycle from the ROB commit port. These are the old_p values rename sent into the ROB with each dispatched bundle.
- Implemented as a circular FIFO of preg tags, sized NUM_PREGS - NUM_AREGS.

Parameters:
- NUM_PREGS, 64, physical register count; tag width PW = clog2(NUM_PREGS) = 6.
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset.
- WIDTH, 4, allocate/free lanes per cycle.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  Reset is asynchronous, active-high.
- i_alloc_count  in  3  number of pregs rename requests this cycle (0..WIDTH).
- o_alloc_ok  out  1  request granted: i_alloc_count <= o_free_count.
- o_alloc_p0..o_alloc_p3  out  6 each  tags at head+0..head+3.
- o_free_count  out  6  entries currently held (0..32).
- i_free_count  in  3  number of retired old pregs returned this cycle (0..WIDTH).
- i_free_p0..i_free_p3  in  6 each  retired old pregs; lane k is valid iff k < i_free_count.

Behaviour:
- Storage: DEPTH = NUM_PREGS - NUM_AREGS = 32 entries of PW bits.
- Pointers: head and tail are 6 bits wide (5 index bits + 1 wrap bit).
- count = tail - head (mod 64), range 0..32. o_free_count = count.
- Reset (async, any time, including mid-operation):
  - head = 0, tail = 32 (wrap bit set, index 0), so count = 32.
  - entry[i] = NUM_AREGS + i, giving p32..p63 in order.
  - Outputs after reset: o_free_count = 32, o_alloc_ok = 1 (any request <= 4), o_alloc_p0..3 = 32, 33, 34, 35.
- Allocation (zero-latency read):
  - o_alloc_pk = entry[(head+k) mod 32], combinational.
  - o_alloc_ok is combinational from i_alloc_count and the registered count.
  - If o_alloc_ok is 1: head += i_alloc_count at the rising edge.
  - If o_alloc_ok is 0: no pop at all; all-or-nothing, never a partial grant.
  - i_alloc_count = 0 gives o_alloc_ok = 1 and no change.
  - Values > 4 are illegal; they are treated as no request (o_alloc_ok = 0).
- Free:
  - At the rising edge, write i_free_pk to entry[(tail+k) mod 32] for k < i_free_count.
  - Then tail += i_free_count.
  - Lanes are packed from lane 0; lanes at or above the count are ignored.
- Simultaneous alloc and free:
  - Both apply in the same edge.
  - Grant uses the count at start of cycle; same-cycle frees are not bypassed to allocation.
  - Next count = count - granted + i_free_count.
- Empty (count = 0): only i_alloc_count = 0 is granted. o_alloc_p* show stale entries and must be ignored by rename.
- Full (count = 32):
  - A free with count + i_free_count - granted > 32 is a protocol violation.
  - Behaviour is undefined; the formal build asserts it never happens.
- Wrap-around: indices are taken mod 32. A 4-wide pop or push straddling entry 31 to entry 0 must be correct.
- No tag filtering: p0 and duplicates are stored as given. Uniqueness is guaranteed by rename/ROB.

Optional Feature:
- Macro: FREELIST_FORMAL_EN.
- When defined, adds f_past_valid and the following properties:
  - assume i_alloc_count <= 4 and i_free_count <= 4;
  - assume no free overflow;
  - assert count <= 32;
  - assert head advances only when o_alloc_ok;
  - assert count(t) = count(t-1) - granted + freed;
  - assert count = 32 one cycle after i_rst falls.
- When undefined: no extra logic. RTL behaviour is identical either way.

Decomposition:
- Shared package: NUM_PREGS, NUM_AREGS, WIDTH, PW, preg_t (logic [PW-1:0]), and a count typedef. The rename map table and ROB use the same package.
- One sub-module, freelist_ptr: wrap-bit pointer register with async reset value and add-by-n increment, instantiated twice (head, tail).

Test Plan:
- Reset release, i_alloc_count = 4 -> o_alloc_ok = 1, o_alloc_p0..3 = 32, 33, 34, 35; next cycle o_free_count = 28, o_alloc_p0 = 36.
- Eight cycles of alloc 4 -> o_free_count = 0. Then alloc 1 -> o_alloc_ok = 0 and count stays 0. Then alloc 0 -> o_alloc_ok = 1.
- From count = 0, free 3 with tags 5, 9, 12 -> count = 3. Next cycle alloc 3 -> o_alloc_p0..2 = 5, 9, 12.
- count = 2, alloc 3 plus free 4 in the same cycle -> o_alloc_ok = 0, head unchanged, next count = 6.
- Wrap case: head at index 30 with 4 entries -> o_alloc_p0..3 read indices 30, 31, 0, 1. Pop 4 plus push 4 -> count unchanged and tags preserved across the wrap.
- Assert i_rst mid-stream with count = 7 -> immediately o_free_count = 32 and o_alloc_p0 = 32, without waiting for a clock edge.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared rename-stage types and sizes (free list, map table, ROB).
package freelist_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned WIDTH     = 4;
    localparam int unsigned PW        = $clog2(NUM_PREGS);
    localparam int unsigned DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int unsigned IW        = $clog2(DEPTH);

    typedef logic [PW-1:0] preg_t;      // physical register tag
    typedef logic [PW-1:0] count_t;     // free-list occupancy, 0..DEPTH
    typedef logic [IW:0]   ptr_t;       // index bits plus one wrap bit
    typedef logic [2:0]    lane_cnt_t;  // per-cycle lane count, 0..WIDTH

endpackage

// File: rtl/freelist_ptr.sv
// Wrap-bit circular-buffer pointer: async reset value, advance by n per cycle.
module freelist_ptr
    import freelist_pkg::*;
#(
    parameter ptr_t RST_VAL = '0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  lane_cnt_t i_inc,
    output ptr_t      o_ptr
);

    ptr_t r_ptr;

    // Pointer register; wrap bit rolls over naturally with the modulo add.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= RST_VAL;
        end else begin
            r_ptr <= r_ptr + ptr_t'(i_inc);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of preg tags, up to WIDTH
// allocations and WIDTH returns per cycle. Optional macro FREELIST_FORMAL_EN
// adds formal assumptions/assertions only; datapath behaviour is unchanged.
module freelist
    import freelist_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  lane_cnt_t i_alloc_count,
    output logic      o_alloc_ok,
    output preg_t     o_alloc_p0,
    output preg_t     o_alloc_p1,
    output preg_t     o_alloc_p2,
    output preg_t     o_alloc_p3,
    output count_t    o_free_count,
    input  lane_cnt_t i_free_count,
    input  preg_t     i_free_p0,
    input  preg_t     i_free_p1,
    input  preg_t     i_free_p2,
    input  preg_t     i_free_p3
);

    ptr_t            w_head;
    ptr_t            w_tail;
    count_t          w_count;
    lane_cnt_t       w_grant;
    logic            w_req_legal;
    preg_t           w_free_p [WIDTH];
    logic [IW-1:0]   w_rd_idx [WIDTH];
    logic [IW-1:0]   w_wr_idx [WIDTH];
    preg_t           r_mem    [DEPTH];

    freelist_ptr #(.RST_VAL(ptr_t'(0))) u_head (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_grant),
        .o_ptr (w_head)
    );

    freelist_ptr #(.RST_VAL(ptr_t'(DEPTH))) u_tail (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (i_free_count),
        .o_ptr (w_tail)
    );

    // Occupancy and all-or-nothing grant against the start-of-cycle count.
    always_comb begin
        w_count     = count_t'(w_tail - w_head);
        w_req_legal = (i_alloc_count <= 3'(WIDTH));
        o_alloc_ok  = w_req_legal && (count_t'(i_alloc_count) <= w_count);
        w_grant     = o_alloc_ok ? i_alloc_count : '0;
    end

    // Lane index generation; indices wrap modulo DEPTH.
    always_comb begin
        w_free_p[0] = i_free_p0;
        w_free_p[1] = i_free_p1;
        w_free_p[2] = i_free_p2;
        w_free_p[3] = i_free_p3;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_rd_idx[k] = w_head[IW-1:0] + IW'(k);
            w_wr_idx[k] = w_tail[IW-1:0] + IW'(k);
        end
    end

    // Tag storage: reset preloads the unmapped pregs, frees pack from lane 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= preg_t'(NUM_AREGS + i);
            end
        end else begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (k < 32'(i_free_count)) begin
                    r_mem[w_wr_idx[k]] <= w_free_p[k];
                end
            end
        end
    end

    assign o_free_count = w_count;
    assign o_alloc_p0   = r_mem[w_rd_idx[0]];
    assign o_alloc_p1   = r_mem[w_rd_idx[1]];
    assign o_alloc_p2   = r_mem[w_rd_idx[2]];
    assign o_alloc_p3   = r_mem[w_rd_idx[3]];

`ifdef FREELIST_FORMAL_EN
    logic f_past_valid;

    // Marks cycles where $past() refers to a post-reset sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_past_valid <= 1'b0;
        end else begin
            f_past_valid <= 1'b1;
        end
    end

    a_legal_counts: assume property (@(posedge i_clk)
        (i_alloc_count <= 3'(WIDTH)) && (i_free_count <= 3'(WIDTH)));

    a_no_overflow: assume property (@(posedge i_clk) disable iff (i_rst)
        ({1'b0, w_count} - {4'b0, w_grant} + {4'b0, i_free_count}) <= 7'(DEPTH));

    p_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        w_count <= count_t'(DEPTH));

    p_head_on_grant: assert property (@(posedge i_clk) disable iff (i_rst)
        (f_past_valid && !$past(o_alloc_ok)) |-> (w_head == $past(w_head)));

    p_count_update: assert property (@(posedge i_clk) disable iff (i_rst)
        f_past_valid |->
            (w_count == count_t'($past(w_count) - count_t'($past(w_grant))
                                 + count_t'($past(i_free_count)))));

    p_reset_full: assert property (@(posedge i_clk)
        ($past(i_rst) && !i_rst) |-> (w_count == count_t'(DEPTH)));
`endif

endmodule
